// File: rtl/fsm_step_ctrl_pkg.sv
// Shared definitions for the step controller: FSM state encoding and switch bit positions.
package fsm_step_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPulse   = 3'd1,
    StHold    = 3'd2,
    StRepeat  = 3'd3,
    StWaitRel = 3'd4
  } state_e;

  localparam int unsigned SwW      = 7;
  localparam int unsigned SwCheck  = 6;
  localparam int unsigned SwMode   = 5;
  localparam int unsigned SwDir    = 4;
  localparam int unsigned SwValLsb = 0;
  localparam int unsigned SwValW   = 4;

endpackage

// File: rtl/fsm_step_ctrl_key_debounce.sv
// Synchronises and debounces the active-low step pushbutton; emits the debounced level and a
// one-cycle event on each debounced press.
module fsm_step_ctrl_key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic clock,
  input  logic reset,
  input  logic step_n,
  output logic level_pressed,
  output logic press_evt
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             pressed_now;
  logic             level_q, level_d;
  logic             evt_q, evt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign pressed_now = ~sync_q[1];

  // Level flips on the edge where the mismatch count reaches DEBOUNCE_CYCLES.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    evt_d   = 1'b0;
    if (pressed_now != level_q) begin
      if (cnt_q >= CntLast) begin
        level_d = pressed_now;
        evt_d   = pressed_now;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q  <= 2'b11;
      level_q <= 1'b0;
      evt_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], step_n};
      level_q <= level_d;
      evt_q   <= evt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_pressed = level_q;
  assign press_evt     = evt_q;

endmodule

// File: rtl/fsm_step_ctrl.sv
// Step command source: debounced button to one-cycle enable, latched switch command,
// optional hold-to-auto-repeat.
module fsm_step_ctrl
  import fsm_step_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           step_n,
  input  logic [SwW-1:0] sw,
  input  logic           auto_repeat,
  output logic           enable,
  output logic           check,
  output logic           mode,
  output logic           direction,
  output logic [3:0]     value,
  output logic           busy
);

  localparam logic [CNT_W-1:0] DelayLast = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RateLast  = CNT_W'(REPEAT_RATE - 1);

  logic           level_pressed, press_evt;
  logic [SwW-1:0] sw_meta_q, sw_sync_q;
  logic           auto_meta_q, auto_sync_q;
  state_e         state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d, timer_last;
  logic           rep_q, rep_d;
  logic [SwW-1:0] cmd_q, cmd_d;

  fsm_step_ctrl_key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_key_debounce (
    .clock        (clock),
    .reset        (reset),
    .step_n       (step_n),
    .level_pressed(level_pressed),
    .press_evt    (press_evt)
  );

  assign timer_last = (state_q == StHold) ? DelayLast : RateLast;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rep_d   = rep_q;
    cmd_d   = cmd_q;
    enable  = 1'b0;
    case (state_q)
      StIdle: begin
        if (press_evt) begin
          state_d = StPulse;
          rep_d   = 1'b0;
          cmd_d   = sw_sync_q;
        end
      end
      StPulse: begin
        enable  = 1'b1;
        timer_d = '0;
        if (auto_sync_q) state_d = rep_q ? StRepeat : StHold;
        else             state_d = StWaitRel;
      end
      StHold, StRepeat: begin
        // Release outranks both auto_repeat dropping and timer expiry.
        if (!level_pressed) begin
          state_d = StIdle;
        end else if (!auto_sync_q) begin
          state_d = StWaitRel;
        end else if (timer_q >= timer_last) begin
          state_d = StPulse;
          rep_d   = 1'b1;
          cmd_d   = sw_sync_q;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      StWaitRel: begin
        if (!level_pressed) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      auto_meta_q <= 1'b0;
      auto_sync_q <= 1'b0;
      state_q     <= StIdle;
      timer_q     <= '0;
      rep_q       <= 1'b0;
      cmd_q       <= '0;
    end else begin
      sw_meta_q   <= sw;
      sw_sync_q   <= sw_meta_q;
      auto_meta_q <= auto_repeat;
      auto_sync_q <= auto_meta_q;
      state_q     <= state_d;
      timer_q     <= timer_d;
      rep_q       <= rep_d;
      cmd_q       <= cmd_d;
    end
  end

  assign check     = cmd_q[SwCheck];
  assign mode      = cmd_q[SwMode];
  assign direction = cmd_q[SwDir];
  assign value     = cmd_q[SwValLsb +: SwValW];
  assign busy      = level_pressed;

endmodule
